comple2_serial: RTL

Parametrised, digit-serial two's-complement unit for the ALU datapath. Computes R = (cmp ? ~A : A) + cin modulo 2^WIDTH, DIGIT bits per clock, with a registered carry between digits. Adds a start/busy/done handshake plus carry-out, signed-overflow and zero flags. Drop-in for the fixed 32-bit ripple complementer wherever area matters more than single-cycle latency.

---
 rtl/comple2_serial.sv | 139 +++++++++++++
 1 files changed

// File: rtl/comple2_serial.sv
// rtl/comple2_serial.sv - digit-serial two's-complement unit
// R = (cmp ? ~A : A) + cin, DIGIT bits per cycle with a registered inter-digit carry.
module comple2_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic             cin_i,
  input  logic             cmp_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] r_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int DSAFE = (DIGIT < 1) ? 1 : DIGIT;
  localparam int NDIG  = WIDTH / DSAFE;
  localparam int KW    = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if (DIGIT < 1 || (WIDTH % DSAFE) != 0) begin : g_bad_params
      $error("comple2_serial: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             cmp_q, cmp_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             zacc_q, zacc_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] a_sh;
  logic [DIGIT-1:0] dig;
  logic [DIGIT:0]   sum;
  logic             last;
  logic             dig_zero;

  // The current digit is selected by shifting the latched operand down by k digits.
  always_comb begin
    a_sh     = a_q >> (int'(k_q) * DIGIT);
    dig      = a_sh[DIGIT-1:0] ^ {DIGIT{cmp_q}};
    sum      = {1'b0, dig} + {{DIGIT{1'b0}}, c_q};
    dig_zero = (sum[DIGIT-1:0] == '0);
    last     = (k_q == KW'(NDIG - 1));
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    c_d     = c_q;
    a_d     = a_q;
    cmp_d   = cmp_q;
    r_d     = r_q;
    zacc_d  = zacc_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          cmp_d   = cmp_i;
          c_d     = cin_i;
          k_d     = '0;
          r_d     = '0;
          zacc_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        r_d[int'(k_q) * DIGIT +: DIGIT] = sum[DIGIT-1:0];
        c_d    = sum[DIGIT];
        zacc_d = zacc_q & dig_zero;
        if (last) begin
          // Overflow only when a non-negative x wraps to a negative result.
          cout_d  = sum[DIGIT];
          ovf_d   = ~(a_q[WIDTH-1] ^ cmp_q) & r_d[WIDTH-1];
          zero_d  = zacc_q & dig_zero;
          done_d  = 1'b1;
          k_d     = '0;
          state_d = IDLE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      k_q     <= '0;
      c_q     <= 1'b0;
      a_q     <= '0;
      cmp_q   <= 1'b0;
      r_q     <= '0;
      zacc_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      c_q     <= c_d;
      a_q     <= a_d;
      cmp_q   <= cmp_d;
      r_q     <= r_d;
      zacc_q  <= zacc_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q == RUN);
  assign done_o = done_q;
  assign r_o    = r_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;
  assign zero_o = zero_q;

endmodule
